cu: RTL and testbench
=====================

# cu

Control unit of the multi-channel codec datapath. After reset it free-runs a fixed per-channel phase sequence (load, quantise, reconstruct, adapt, store) across all channels of a frame, emitting one-hot phase strobes and the current channel index to the datapath. All state flops form one scan chain, `scan_in0` to `scan_out0`, for DFT.

## Interface
Parameters:
- `NUM_CH`, 32: channels per frame; must be at least 2.
- `ADAPT_CYC`, 4: cycles spent in ADAPT; must be at least 1.

Ports:
- `clk` input 1: single clock; all flops are rising-edge.
- `reset` input 1: reset is synchronous and active-high.
- `scan_in0` input 1: serial scan data in.
- `scan_enable` input 1: 1 = shift the scan chain; 0 = functional operation.
- `scan_out0` output 1: serial scan data out; the last flop of the chain.
- `ch_idx` output clog2(NUM_CH): current channel.
- `state` output 3: current FSM state code.
- `load_en`, `quant_en`, `recon_en`, `adapt_en`, `store_en` output 1 each: phase strobes.
- `frame_start` output 1: high during LOAD of channel 0.
- `frame_done` output 1: high during FEND.
- `frame_cnt` output 8: count of completed frames; wraps 255 to 0.

## Operation
- State codes: IDLE=0, LOAD=1, QUANT=2, RECON=3, ADAPT=4, STORE=5, FEND=6. Code 7 is illegal.
- Transitions:
  - IDLE goes to LOAD.
  - LOAD goes to QUANT.
  - QUANT goes to RECON.
  - RECON goes to ADAPT and clears the adapt counter.
  - ADAPT stays for ADAPT_CYC cycles in total, then goes to STORE.
  - STORE goes to LOAD with ch_idx+1 if ch_idx < NUM_CH-1; otherwise it goes to FEND.
  - FEND goes to LOAD, sets ch_idx=0 and increments frame_cnt (mod 256).
  - Illegal code 7 goes to IDLE on the next functional edge.
- Each strobe is a combinational decode of `state`, one-hot. All strobes, `frame_start` and `frame_done` are forced to 0 while `scan_enable`=1.
- Reset (`reset`=1 with `scan_enable`=0) sets state=IDLE, ch_idx=0, the adapt counter to 0 and frame_cnt=0. All strobes are 0 in IDLE.
- Reset asserted mid-frame aborts the frame immediately. No partial STORE is generated.
- Scan shift (`scan_enable`=1) takes priority over `reset` and over functional update. Every flop loads its chain predecessor.
- Scan chain order, from `scan_in0`: state[0..2], adapt counter LSB-first, ch_idx LSB-first, frame_cnt[0..7]. `scan_out0` is frame_cnt[7].
- Chain length is 3 + clog2(ADAPT_CYC) + clog2(NUM_CH) + 8, which is 18 with default parameters.
- Releasing `scan_enable` resumes functional operation from the shifted-in state. Illegal codes recover through IDLE.

## Timing
- Sequence after reset: IDLE for 1 cycle, then LOAD of ch0 on the next cycle.
- Per channel: 3 + ADAPT_CYC + 1 cycles, which is 8 by default.
- Frame period: NUM_CH × (4 + ADAPT_CYC) + 1 cycles, which is 257 by default. IDLE is not repeated between frames.
- frame_cnt and ch_idx update on the edge that leaves FEND.
- Strobes are valid in the same cycle as `state`. There is no output register stage.
- `scan_out0` changes only on clock edges with `scan_enable`=1, or when frame_cnt[7] changes functionally.

## Configuration
- Macro `CU_SCAN_CHAIN_EN`.
- With the macro defined: the scan mux and chain are implemented as described above.
- Without the macro:
  - `scan_enable` and `scan_in0` are ignored.
  - `scan_out0` is tied to 0.
  - Strobes are never gated by `scan_enable`.
  - The ports remain present.

## Test plan
- Reset idle: `reset`=1 for 2 cycles, all scan inputs 0 → state=0, ch_idx=0, frame_cnt=0, all strobes 0, `scan_out0`=0.
- Channel sequence: release reset → state codes 0,1,2,3,4,4,4,4,5,1 on consecutive cycles; ch_idx goes 0 to 1 on the edge after STORE; `frame_start` is high only in the first LOAD.
- Frame wrap: run 257 cycles after IDLE → FEND seen once with `frame_done`=1, then LOAD with ch_idx=0 and frame_cnt=1. After 256 frames, frame_cnt reads 0.
- Mid-frame reset: assert `reset` during ADAPT of ch 5 → the next cycle shows state=0, ch_idx=0, frame_cnt=0, and no store_en pulse.
- Scan shift: `scan_enable`=1 with `reset`=1; shift 18-bit pattern 0x2A5C3 → the same bits emerge on `scan_out0` after 18 cycles, and strobes stay 0 throughout.
- Scan load/resume: shift in state=7, ch_idx=31, then drop `scan_enable` → state=0 on the next cycle, followed by LOAD with ch_idx=31. Also shift in STORE with ch=31 → FEND follows.

Source files
------------

// File: rtl/cu.sv
// Codec datapath control unit: free-running per-channel phase sequencer with one-hot strobes.
// Define CU_SCAN_CHAIN_EN to build the scan mux and chain (scan_in0 -> scan_out0).
module cu #(
  parameter int NUM_CH    = 32,
  parameter int ADAPT_CYC = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      scan_in0,
  input  logic                      scan_enable,
  output logic                      scan_out0,
  output logic [$clog2(NUM_CH)-1:0] ch_idx,
  output logic [2:0]                state,
  output logic                      load_en,
  output logic                      quant_en,
  output logic                      recon_en,
  output logic                      adapt_en,
  output logic                      store_en,
  output logic                      frame_start,
  output logic                      frame_done,
  output logic [7:0]                frame_cnt
);

  // state  | meaning
  // IDLE   | post-reset / illegal-code recovery, one cycle
  // LOAD   | load channel sample
  // QUANT  | quantise
  // RECON  | reconstruct, clear adapt counter
  // ADAPT  | adapt for ADAPT_CYC cycles
  // STORE  | store, advance channel or end frame
  // FEND   | frame end, wrap channel, bump frame count

  localparam int CW = $clog2(NUM_CH);
  // A single-cycle ADAPT still keeps a 1-bit counter so the vector is never zero width.
  localparam int AW = (ADAPT_CYC > 1) ? $clog2(ADAPT_CYC) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_QUANT = 3'd2,
    S_RECON = 3'd3,
    S_ADAPT = 3'd4,
    S_STORE = 3'd5,
    S_FEND  = 3'd6
  } state_t;

  state_t          st_q, st_d;
  logic [AW-1:0]   cnt_q, cnt_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic [7:0]      fc_q, fc_d;
  logic            gate;

  always_comb begin
    st_d  = S_IDLE;
    cnt_d = cnt_q;
    ch_d  = ch_q;
    fc_d  = fc_q;
    case (st_q)
      S_IDLE:  st_d = S_LOAD;
      S_LOAD:  st_d = S_QUANT;
      S_QUANT: st_d = S_RECON;
      S_RECON: begin
        st_d  = S_ADAPT;
        cnt_d = '0;
      end
      S_ADAPT: begin
        // >= so an out-of-range count loaded by scan still exits
        if (cnt_q >= AW'(ADAPT_CYC - 1)) begin
          st_d = S_STORE;
        end else begin
          st_d  = S_ADAPT;
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_STORE: begin
        if (ch_q >= CW'(NUM_CH - 1)) begin
          st_d = S_FEND;
        end else begin
          st_d = S_LOAD;
          ch_d = ch_q + 1'b1;
        end
      end
      S_FEND: begin
        st_d = S_LOAD;
        ch_d = '0;
        fc_d = fc_q + 8'd1;
      end
      default: st_d = S_IDLE;
    endcase
  end

`ifdef CU_SCAN_CHAIN_EN
  localparam int CL = 3 + AW + CW + 8;
  logic [CL-1:0] chain_sh;
  assign chain_sh = {fc_q, ch_q, cnt_q, st_q[1:0], scan_in0};
  assign gate      = scan_enable;
  assign scan_out0 = fc_q[7];
`else
  logic unused_scan;
  assign unused_scan = scan_in0 ^ scan_enable;
  assign gate        = 1'b0;
  assign scan_out0   = 1'b0;
`endif

  always_ff @(posedge clk) begin
`ifdef CU_SCAN_CHAIN_EN
    if (scan_enable) begin
      st_q  <= state_t'(chain_sh[2:0]);
      cnt_q <= chain_sh[3 +: AW];
      ch_q  <= chain_sh[3 + AW +: CW];
      fc_q  <= chain_sh[CL-1 -: 8];
    end else
`endif
    if (reset) begin
      st_q  <= S_IDLE;
      cnt_q <= '0;
      ch_q  <= '0;
      fc_q  <= '0;
    end else begin
      st_q  <= st_d;
      cnt_q <= cnt_d;
      ch_q  <= ch_d;
      fc_q  <= fc_d;
    end
  end

  assign state       = st_q;
  assign ch_idx      = ch_q;
  assign frame_cnt   = fc_q;
  assign load_en     = (st_q == S_LOAD)  & ~gate;
  assign quant_en    = (st_q == S_QUANT) & ~gate;
  assign recon_en    = (st_q == S_RECON) & ~gate;
  assign adapt_en    = (st_q == S_ADAPT) & ~gate;
  assign store_en    = (st_q == S_STORE) & ~gate;
  assign frame_start = load_en & (ch_q == '0);
  assign frame_done  = (st_q == S_FEND)  & ~gate;

endmodule

// File: tb/tb_cu.sv
// Self-checking bench for cu: timing-arithmetic reference model, random run lengths,
// random mid-frame resets and (with CU_SCAN_CHAIN_EN) scan shift/load checks.
module tb_cu;
  localparam int NUM_CH    = 32;
  localparam int ADAPT_CYC = 4;
  localparam int CW        = $clog2(NUM_CH);
  localparam int AW        = (ADAPT_CYC > 1) ? $clog2(ADAPT_CYC) : 1;
  localparam int CL        = 3 + AW + CW + 8;
  localparam int PER_CH    = 4 + ADAPT_CYC;
  localparam int PERIOD    = NUM_CH * PER_CH + 1;

  logic          clk;
  logic          reset;
  logic          scan_in0;
  logic          scan_enable;
  logic          scan_out0;
  logic [CW-1:0] ch_idx;
  logic [2:0]    state;
  logic          load_en, quant_en, recon_en, adapt_en, store_en;
  logic          frame_start, frame_done;
  logic [7:0]    frame_cnt;

  int n_chk  = 0;
  int n_fail = 0;
  int t;

  cu #(.NUM_CH(NUM_CH), .ADAPT_CYC(ADAPT_CYC)) dut (
    .clk(clk), .reset(reset), .scan_in0(scan_in0), .scan_enable(scan_enable),
    .scan_out0(scan_out0), .ch_idx(ch_idx), .state(state),
    .load_en(load_en), .quant_en(quant_en), .recon_en(recon_en),
    .adapt_en(adapt_en), .store_en(store_en),
    .frame_start(frame_start), .frame_done(frame_done), .frame_cnt(frame_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0d, time %0t)", tag, obs, exp, t, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [6:0] obs_sig();
    return {frame_done, frame_start, store_en, adapt_en, recon_en, quant_en, load_en};
  endfunction

  // {frame_done, frame_start, store, adapt, recon, quant, load}
  function automatic logic [6:0] exp_sig(input int st, input int ch, input bit gated);
    logic [6:0] s;
    s = '0;
    if (!gated) begin
      if (st >= 1 && st <= 5) s[st-1] = 1'b1;
      s[5] = (st == 1) && (ch == 0);
      s[6] = (st == 6);
    end
    return s;
  endfunction

  // Expected outputs from elapsed functional cycles since reset, using frame/channel arithmetic.
  task automatic check_model(input int tt);
    int q, p, ph, ex_st, ex_ch, ex_fc;
    if (tt == 0) begin
      ex_st = 0; ex_ch = 0; ex_fc = 0;
    end else begin
      q     = tt - 1;
      ex_fc = (q / PERIOD) % 256;
      p     = q % PERIOD;
      if (p == PERIOD - 1) begin
        ex_st = 6; ex_ch = NUM_CH - 1;
      end else begin
        ex_ch = p / PER_CH;
        ph    = p % PER_CH;
        if (ph < 3) ex_st = ph + 1;
        else if (ph < 3 + ADAPT_CYC) ex_st = 4;
        else ex_st = 5;
      end
    end
    check_val("state", state, ex_st);
    check_val("ch_idx", ch_idx, ex_ch);
    check_val("frame_cnt", frame_cnt, ex_fc);
    check_val("strobes", obs_sig(), exp_sig(ex_st, ex_ch, 1'b0));
`ifdef CU_SCAN_CHAIN_EN
    check_val("scan_out_func", scan_out0, (ex_fc >> 7) & 1);
`else
    check_val("scan_out_tied", scan_out0, 0);
`endif
  endtask

  // Without the scan build the scan pins must be don't-cares, so toggle them freely.
  task automatic fuzz_scan();
`ifndef CU_SCAN_CHAIN_EN
    scan_enable = 1'($urandom);
    scan_in0    = 1'($urandom);
`endif
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      fuzz_scan();
      step();
      t++;
      check_model(t);
    end
  endtask

  task automatic apply_reset(input int n);
    reset = 1'b1;
    for (int i = 0; i < n; i++) begin
      fuzz_scan();
      step();
      t = 0;
      check_model(0);
    end
    reset = 1'b0;
  endtask

`ifdef CU_SCAN_CHAIN_EN
  task automatic scan_load(input logic [CL-1:0] v);
    reset       = 1'b1;
    scan_enable = 1'b1;
    for (int i = CL - 1; i >= 0; i--) begin
      scan_in0 = v[i];
      step();
      check_val("scan_load_gate", obs_sig(), 0);
    end
    check_val("scan_load_state", state, v[2:0]);
    check_val("scan_load_ch", ch_idx, v[3+AW +: CW]);
    check_val("scan_load_fc", frame_cnt, v[CL-1 -: 8]);
    reset       = 1'b0;
    scan_enable = 1'b0;
    scan_in0    = 1'b0;
  endtask
`endif

  initial begin
    logic [CL-1:0] pat;
    logic [CL-1:0] v;
    logic [7:0]    r;
    int            tgt;

    reset = 1'b1; scan_enable = 1'b0; scan_in0 = 1'b0; t = 0;
    repeat (2) step();
    check_model(0);
    reset = 1'b0;

    // 256 full frames plus the following LOAD: covers frame wrap and frame_cnt rollover.
    run(256 * PERIOD + 1);
    check_val("frame_cnt_rollover", frame_cnt, 0);

    // Reset during ADAPT of channel 5.
    apply_reset(1);
    tgt = 1 + 5 * PER_CH + 3;
    run(tgt);
    check_val("pre_reset_state", state, 4);
    check_val("pre_reset_ch", ch_idx, 5);
    apply_reset(1);
    check_val("no_store_after_reset", store_en, 0);

    for (int k = 0; k < 8; k++) begin
      run($urandom_range(1, 700));
      apply_reset($urandom_range(1, 3));
    end
    run($urandom_range(10, 300));

`ifdef CU_SCAN_CHAIN_EN
    for (int k = 0; k < 2; k++) begin
      pat = (k == 0) ? CL'(32'h2A5C3) : CL'($urandom);
      reset       = 1'b1;
      scan_enable = 1'b1;
      for (int i = 0; i < CL; i++) begin
        scan_in0 = pat[i];
        step();
        check_val("scan_gate", obs_sig(), 0);
      end
      for (int i = 0; i < CL; i++) begin
        check_val("scan_out", scan_out0, pat[i]);
        scan_in0 = 1'($urandom);
        step();
        check_val("scan_gate", obs_sig(), 0);
      end
    end

    // Illegal code with last channel: recover via IDLE, keep channel.
    v = {8'd0, CW'(NUM_CH - 1), AW'(0), 3'd7};
    scan_load(v);
    check_val("illegal_strobes", obs_sig(), 0);
    step();
    check_val("recover_state", state, 0);
    check_val("recover_ch", ch_idx, NUM_CH - 1);
    step();
    check_val("resume_state", state, 1);
    check_val("resume_ch", ch_idx, NUM_CH - 1);
    check_val("resume_strobes", obs_sig(), exp_sig(1, NUM_CH - 1, 1'b0));

    // STORE on last channel goes to FEND, then wraps the frame.
    r = 8'($urandom);
    v = {r, CW'(NUM_CH - 1), AW'(0), 3'd5};
    scan_load(v);
    check_val("store_strobes", obs_sig(), exp_sig(5, NUM_CH - 1, 1'b0));
    step();
    check_val("fend_state", state, 6);
    check_val("fend_strobes", obs_sig(), exp_sig(6, NUM_CH - 1, 1'b0));
    check_val("fend_fc", frame_cnt, r);
    step();
    check_val("wrap_state", state, 1);
    check_val("wrap_ch", ch_idx, 0);
    check_val("wrap_fc", frame_cnt, 8'(r + 8'd1));
    check_val("wrap_strobes", obs_sig(), exp_sig(1, 0, 1'b0));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
